ysyx_25040129_icache_assoc: RTL and testbench
=============================================

// Module: ysyx_25040129_icache_assoc
// PURPOSE
//  Parametrised N-way set-associative instruction cache between the IFU and the AXI memory port.
//  Hits answer in the request cycle. Misses fetch a whole line with one INCR burst, critical word returned.
//  Per-set round-robin replacement, fence.i flush, hit/miss performance counters.
//  Successor to the direct-mapped single-word-fill icache; drop-in on the same IFU/AXI ports.
// PARAMETERS
//  WAYS            2   ways per set; legal values 1, 2, 4
//  SET_DIG         3   log2(number of sets)
//  LINE_WORD_DIG   2   log2(32-bit words per line); LINE_WORD_DIG >= 1
//  Derived: OFF = LINE_WORD_DIG+2, IDX = addr[OFF+SET_DIG-1:OFF], TAG = addr[31:OFF+SET_DIG], WORD = addr[OFF-1:2]
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous, active-high reset
//  ifu_araddr   in   32  fetch address (word aligned)
//  ifu_arvalid  in   1   fetch request valid
//  ifu_arready  out  1   = (state==IDLE) & !fence_i & !flush_pend
//  ifu_rdata    out  32  instruction word
//  ifu_rresp    out  2   00 OKAY, 10 SLVERR
//  ifu_rvalid   out  1   response valid
//  ifu_rready   in   1   IFU accepts response
//  out_araddr   out  32  line-aligned miss address: {latched_addr[31:OFF], OFF'b0}
//  out_arvalid  out  1   burst request valid
//  out_arready  in   1   burst request accepted
//  out_arlen    out  8   constant 2^LINE_WORD_DIG-1
//  out_arburst  out  2   constant 2'b01 (INCR)
//  out_rdata    in   32  burst beat data
//  out_rresp    in   2   burst beat response
//  out_rvalid   in   1   beat valid
//  out_rready   out  1   = (state==FILL)
//  out_rlast    in   1   last beat
//  fence_i      in   1   invalidate all lines
//  perf_hit     out  32  accepted-hit count, wraps at 2^32
//  perf_miss    out  32  accepted-miss count, wraps at 2^32
// BEHAVIOUR
//  States: IDLE, RESP (hold response), AR (out_arvalid=1), FILL (out_rready=1).
//  Reset: state=IDLE, all valid bits 0, RR pointers 0, flush_pend 0, counters 0, rdata/rresp latches 0.
//   Outputs after reset: arready=1, rvalid=0, arvalid=0, rready=0.
//  IDLE, fence_i|flush_pend: clear all valid bits this cycle, clear flush_pend, accept nothing. fence_i wins over a same-cycle arvalid.
//  fence_i in RESP/AR/FILL: set flush_pend; the in-flight fill still completes and is returned, then flushed in IDLE.
//  IDLE, arvalid, hit (any way valid & tag equal): same cycle ifu_rvalid=1, ifu_rdata=way data, rresp=00, perf_hit+1.
//   If !ifu_rready, latch the word and go RESP; else stay IDLE (back-to-back hits at 1/cycle).
//  IDLE, arvalid, miss: latch addr, choose victim, beat=0, err=0, perf_miss+1, go AR.
//   Victim = lowest-index invalid way in the set, else rr[set].
//  AR: hold out_arvalid; out_araddr stable until out_arready; -> FILL.
//  FILL, each out_rvalid beat: write data[set][victim][beat]; beat+1 (wraps modulo line size).
//   Beat == WORD: latch into ifu_rdata. Any out_rresp!=00 sets err.
//  FILL, rvalid & rlast: if !err, write tag and set valid; if err, leave the way invalid.
//   Advance rr[set] (mod WAYS) only when victim came from rr. Set rresp = err?10:00, go RESP.
//  Fills are not exposed early: ifu_rvalid stays 0 through AR/FILL.
//  RESP: ifu_rvalid=1 with the latched rdata/rresp; on ifu_rready -> IDLE.
//  Latency: hit 0 cycles after accept; miss = AR wait + burst + 1 (RESP).
//  rlast is authoritative. A short burst validates the line only if err=0; unwritten words are undefined (not a supported memory behaviour).
//  Reset mid-fill: abandons the burst; the AXI side must be reset together.
//  WAYS==1 degenerates to direct-mapped; the rr pointer is unused.
// TESTING
//  Reset, then fetch 0x8000_0000 -> miss: out_araddr=0x8000_0000, arlen=3, burst=01; after 4 beats rvalid with beat0 data; perf_miss=1.
//  Refetch 0x8000_0004 -> rvalid same cycle as arvalid, beat1 data, no out_arvalid; perf_hit=1.
//  WAYS=2: fill 0x8000_0000, 0x8000_0080 and 0x8000_0100 (same set 0) -> third evicts way0; refetching 0x8000_0000 misses.
//  fence_i during FILL -> response still returned with correct data; next IDLE cycle clears valid; refetch misses.
//  Beat 2 with out_rresp=10 -> ifu_rresp=10; refetching the same line misses again.
//  ifu_rready low for 3 cycles on a hit -> rvalid held, rdata stable, ifu_arready=0 until accepted.

Source files
------------

// File: rtl/ysyx_25040129_icache_assoc.sv
// N-way set-associative instruction cache: same-cycle hits, whole-line INCR fill,
// per-set round-robin replacement, fence.i flush and hit/miss counters.
module ysyx_25040129_icache_assoc #(
  parameter int WAYS          = 2,
  parameter int SET_DIG       = 3,
  parameter int LINE_WORD_DIG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [31:0] out_araddr,
  output logic        out_arvalid,
  input  logic        out_arready,
  output logic [7:0]  out_arlen,
  output logic [1:0]  out_arburst,
  input  logic [31:0] out_rdata,
  input  logic [1:0]  out_rresp,
  input  logic        out_rvalid,
  output logic        out_rready,
  input  logic        out_rlast,
  input  logic        fence_i,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
);
  localparam int OFF   = LINE_WORD_DIG + 2;
  localparam int SETS  = 1 << SET_DIG;
  localparam int WORDS = 1 << LINE_WORD_DIG;
  localparam int TAG_W = 32 - OFF - SET_DIG;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, RESP, AR, FILL} state_t;
  state_t state_q, state_d;

  logic [31:0]        data_q  [SETS][WAYS][WORDS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAY_W-1:0]   rr_q    [SETS];

  logic [31:2]              addr_q;
  logic [WAY_W-1:0]         victim_q;
  logic                     vic_rr_q;
  logic [LINE_WORD_DIG-1:0] beat_q;
  logic                     err_q;
  logic                     flush_pend_q;
  logic [31:0]              rdata_q;
  logic [1:0]               rresp_q;

  logic [SET_DIG-1:0]       req_idx, fill_idx;
  logic [TAG_W-1:0]         req_tag;
  logic [LINE_WORD_DIG-1:0] req_word, fill_word;
  logic                     hit, vic_rr, flush_now, hit_acc, miss_acc;
  logic                     beat_fire, beat_err, fill_err;
  logic [31:0]              hit_data;
  logic [WAY_W-1:0]         victim;
  logic                     unused_addr_lsb;

  assign req_idx   = ifu_araddr[OFF+SET_DIG-1:OFF];
  assign req_tag   = ifu_araddr[31:OFF+SET_DIG];
  assign req_word  = ifu_araddr[OFF-1:2];
  assign fill_idx  = addr_q[OFF+SET_DIG-1:OFF];
  assign fill_word = addr_q[OFF-1:2];
  assign unused_addr_lsb = ^ifu_araddr[1:0];

  assign out_araddr  = {addr_q[31:OFF], {OFF{1'b0}}};
  assign out_arlen   = 8'(WORDS - 1);
  assign out_arburst = 2'b01;

  assign flush_now   = (state_q == IDLE) && (fence_i || flush_pend_q);
  assign ifu_arready = (state_q == IDLE) && !fence_i && !flush_pend_q;
  assign hit_acc     = ifu_arready && ifu_arvalid && hit;
  assign miss_acc    = ifu_arready && ifu_arvalid && !hit;
  assign beat_fire   = (state_q == FILL) && out_rvalid;
  assign beat_err    = (out_rresp != 2'b00);
  assign fill_err    = err_q || beat_err;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit      = 1'b1;
        hit_data = data_q[req_idx][w][req_word];
      end
    end
  end

  // Descending scan so the lowest-index invalid way is the one that sticks.
  always_comb begin
    victim = rr_q[req_idx];
    vic_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        victim = WAY_W'(w);
        vic_rr = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = rdata_q;
    ifu_rresp   = rresp_q;
    out_arvalid = 1'b0;
    out_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_acc) begin
          ifu_rvalid = 1'b1;
          ifu_rdata  = hit_data;
          ifu_rresp  = 2'b00;
          if (!ifu_rready) state_d = RESP;
        end else if (miss_acc) begin
          state_d = AR;
        end
      end
      RESP: begin
        ifu_rvalid = 1'b1;
        if (ifu_rready) state_d = IDLE;
      end
      AR: begin
        out_arvalid = 1'b1;
        if (out_arready) state_d = FILL;
      end
      FILL: begin
        out_rready = 1'b1;
        if (out_rvalid && out_rlast) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      addr_q       <= '0;
      victim_q     <= '0;
      vic_rr_q     <= 1'b0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= 2'b00;
      perf_hit     <= '0;
      perf_miss    <= '0;
    end else begin
      if (flush_now) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        flush_pend_q <= 1'b0;
      end else if (fence_i) begin
        flush_pend_q <= 1'b1;
      end
      if (hit_acc) begin
        perf_hit <= perf_hit + 32'd1;
        rdata_q  <= hit_data;
        rresp_q  <= 2'b00;
      end
      if (miss_acc) begin
        addr_q    <= ifu_araddr[31:2];
        victim_q  <= victim;
        vic_rr_q  <= vic_rr;
        beat_q    <= '0;
        err_q     <= 1'b0;
        perf_miss <= perf_miss + 32'd1;
      end
      if (beat_fire) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == fill_word) rdata_q <= out_rdata;
        if (beat_err) err_q <= 1'b1;
        if (out_rlast) begin
          // A faulted line stays invalid so the next fetch retries memory.
          if (!fill_err) valid_q[fill_idx][victim_q] <= 1'b1;
          if (vic_rr_q)
            rr_q[fill_idx] <= (rr_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[fill_idx] + 1'b1;
          rresp_q <= fill_err ? 2'b10 : 2'b00;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) begin
      data_q[fill_idx][victim_q][beat_q] <= out_rdata;
      if (out_rlast && !fill_err) tag_q[fill_idx][victim_q] <= addr_q[31:OFF+SET_DIG];
    end
  end
endmodule

// File: tb/tb_ysyx_25040129_icache_assoc.sv
// Scoreboard bench for the set-associative icache: directed fetches against a
// behavioural AXI burst memory, responses checked by an independent monitor.
module tb_ysyx_25040129_icache_assoc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ifu_araddr = '0;
  logic        ifu_arvalid = 1'b0;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready = 1'b1;
  logic [31:0] out_araddr;
  logic        out_arvalid;
  logic        out_arready = 1'b0;
  logic [7:0]  out_arlen;
  logic [1:0]  out_arburst;
  logic [31:0] out_rdata = '0;
  logic [1:0]  out_rresp = '0;
  logic        out_rvalid = 1'b0;
  logic        out_rready;
  logic        out_rlast = 1'b0;
  logic        fence_i = 1'b0;
  logic [31:0] perf_hit, perf_miss;

  ysyx_25040129_icache_assoc #(.WAYS(2), .SET_DIG(3), .LINE_WORD_DIG(2)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .out_araddr(out_araddr), .out_arvalid(out_arvalid), .out_arready(out_arready),
    .out_arlen(out_arlen), .out_arburst(out_arburst),
    .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rvalid(out_rvalid),
    .out_rready(out_rready), .out_rlast(out_rlast),
    .fence_i(fence_i), .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ar_cnt = 0;
  int err_beat = -1;
  logic [31:0] exp_line = '0;
  logic [33:0] exp_q[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ifu_rvalid && ifu_rready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("resp_data", ifu_rdata, e[31:0]);
        chk("resp_code", {30'd0, ifu_rresp}, {30'd0, e[33:32]});
      end
    end
  end

  // AXI memory: one-cycle AR wait, then a 4-beat INCR burst from the line base.
  initial begin
    logic [31:0] base;
    forever begin
      @(negedge clk);
      if (!rst && out_arvalid) begin
        @(negedge clk);
        chk("araddr", out_araddr, exp_line);
        chk("arlen", {24'd0, out_arlen}, 32'd3);
        chk("arburst", {30'd0, out_arburst}, 32'd1);
        base = out_araddr;
        ar_cnt++;
        out_arready = 1'b1;
        @(negedge clk);
        out_arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          out_rvalid = 1'b1;
          out_rdata  = mem(base + 32'(4 * k));
          out_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
          out_rlast  = (k == 3);
          if (!out_rready) chk("fill_rready", {31'd0, out_rready}, 32'd1);
          @(negedge clk);
        end
        out_rvalid = 1'b0;
        out_rlast  = 1'b0;
        out_rresp  = 2'b00;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [1:0] rsp, input bit is_hit, input int hold);
    int n;
    exp_line = {a[31:4], 4'h0};
    exp_q.push_back({rsp, mem(a)});
    @(posedge clk); #1;
    ifu_araddr  = a;
    ifu_arvalid = 1'b1;
    ifu_rready  = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!ifu_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("arready_wait", {31'd0, ifu_arready}, 32'd1);
    chk("same_cycle_hit", {31'd0, ifu_rvalid}, {31'd0, is_hit});
    @(posedge clk); #1;
    ifu_arvalid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rvalid", {31'd0, ifu_rvalid}, 32'd1);
      chk("hold_rdata", ifu_rdata, mem(a));
      chk("hold_arready", {31'd0, ifu_arready}, 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      ifu_rready = 1'b1;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("resp_done", exp_q.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_arready", {31'd0, ifu_arready}, 32'd1);
    chk("rst_rvalid", {31'd0, ifu_rvalid}, 32'd0);
    chk("rst_arvalid", {31'd0, out_arvalid}, 32'd0);
    chk("rst_rready", {31'd0, out_rready}, 32'd0);
    chk("rst_perf_hit", perf_hit, 32'd0);
    chk("rst_perf_miss", perf_miss, 32'd0);

    fetch(32'h8000_0000, 2'b00, 1'b0, 0);
    chk("miss1_count", perf_miss, 32'd1);
    chk("miss1_bursts", 32'(ar_cnt), 32'd1);
    fetch(32'h8000_0004, 2'b00, 1'b1, 0);
    chk("hit1_count", perf_hit, 32'd1);
    chk("hit1_no_burst", 32'(ar_cnt), 32'd1);

    fetch(32'h8000_008C, 2'b00, 1'b0, 0);
    fetch(32'h8000_010C, 2'b00, 1'b0, 0);
    fetch(32'h8000_0080, 2'b00, 1'b1, 0);
    fetch(32'h8000_0000, 2'b00, 1'b0, 0);
    chk("evict_bursts", 32'(ar_cnt), 32'd4);

    fetch(32'h8000_0008, 2'b00, 1'b1, 3);

    fork
      fetch(32'h8000_0214, 2'b00, 1'b0, 0);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_rready && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("fence_saw_fill", {31'd0, out_rready}, 32'd1);
        @(posedge clk); #1 fence_i = 1'b1;
        @(posedge clk); #1 fence_i = 1'b0;
      end
    join
    fetch(32'h8000_0008, 2'b00, 1'b0, 0);
    fetch(32'h8000_0214, 2'b00, 1'b0, 0);
    chk("fence_bursts", 32'(ar_cnt), 32'd7);

    err_beat = 2;
    fetch(32'h8000_0300, 2'b10, 1'b0, 0);
    err_beat = -1;
    fetch(32'h8000_0304, 2'b00, 1'b0, 0);
    fetch(32'h8000_0308, 2'b00, 1'b1, 0);

    chk("final_perf_hit", perf_hit, 32'd4);
    chk("final_perf_miss", perf_miss, 32'd9);
    chk("final_bursts", 32'(ar_cnt), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
